// File: rtl/nvram_pkg.sv
// Shared types and constants for the NVRAM upload path.
// Consumed by nvram_uploader; see that file for the NVRAM_CHECKSUM_EN option.
package nvram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      LAT  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [7:0] FILL_BYTE  = 8'hFF;
   localparam int         RD_LAT_MAX = 3;

endpackage

// File: rtl/nvram_uploader.sv
// Serves HPS upload byte requests from a shared NVRAM port behind an external arbiter.
// Optional NVRAM_CHECKSUM_EN appends a two's-complement checksum byte at address SIZE.
module nvram_uploader
   import nvram_pkg::*;
#(
   parameter logic [7:0] UPLOAD_INDEX = 8'd4,
   parameter int         ADDR_W       = 10,
   parameter int         SIZE         = 1024,
   parameter int         RD_LAT       = 1
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_upload,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_rd,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   output logic              ram_req,
   input  logic              ram_gnt,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        ram_q,
   output logic              busy
);

   // Out-of-range latencies are clamped so the counter width stays fixed.
   localparam int          LAT_N    = (RD_LAT < 1) ? 1 :
                                      ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
   localparam logic [1:0]  LAT_LAST = 2'(LAT_N - 1);
   localparam logic [24:0] SIZE_A   = 25'(SIZE);

   state_t              state_reg, state_next;
   logic [7:0]          din_reg, din_next;
   logic                wait_reg, wait_next;
   logic                req_reg, req_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [1:0]          lat_reg, lat_next;
   logic                fill_sel_reg, fill_sel_next;
   logic [7:0]          fill_reg, fill_next;
   logic                active;
   logic                in_range;
   logic [7:0]          slot_byte;

   assign active   = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
   assign in_range = ioctl_addr < SIZE_A;

`ifdef NVRAM_CHECKSUM_EN
   logic [7:0] sum_reg, sum_next;
   logic       active_reg;

   assign slot_byte = (ioctl_addr == SIZE_A) ? (8'd0 - sum_reg) : FILL_BYTE;
`else
   assign slot_byte = FILL_BYTE;
`endif

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         din_reg      <= 8'd0;
         wait_reg     <= 1'b0;
         req_reg      <= 1'b0;
         addr_reg     <= '0;
         lat_reg      <= 2'd0;
         fill_sel_reg <= 1'b0;
         fill_reg     <= 8'd0;
`ifdef NVRAM_CHECKSUM_EN
         sum_reg      <= 8'd0;
         active_reg   <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         din_reg      <= din_next;
         wait_reg     <= wait_next;
         req_reg      <= req_next;
         addr_reg     <= addr_next;
         lat_reg      <= lat_next;
         fill_sel_reg <= fill_sel_next;
         fill_reg     <= fill_next;
`ifdef NVRAM_CHECKSUM_EN
         sum_reg      <= sum_next;
         active_reg   <= active;
`endif
      end
   end

   always_comb begin
      state_next    = state_reg;
      din_next      = din_reg;
      wait_next     = wait_reg;
      req_next      = req_reg;
      addr_next     = addr_reg;
      lat_next      = lat_reg;
      fill_sel_next = fill_sel_reg;
      fill_next     = fill_reg;
`ifdef NVRAM_CHECKSUM_EN
      sum_next      = sum_reg;
`endif

      case (state_reg)
         IDLE: begin
            if (ioctl_rd && active) begin
               wait_next = 1'b1;
               if (in_range) begin
                  state_next    = REQ;
                  addr_next     = ioctl_addr[ADDR_W-1:0];
                  req_next      = 1'b1;
                  fill_sel_next = 1'b0;
               end else begin
                  // No RAM access: answer with the fill/checksum byte via DONE.
                  state_next    = DONE;
                  fill_sel_next = 1'b1;
                  fill_next     = slot_byte;
               end
            end
         end
         REQ: begin
            if (ram_gnt) begin
               state_next = LAT;
               lat_next   = 2'd0;
            end
         end
         LAT: begin
            if (!ram_gnt) begin
               state_next = REQ;
               lat_next   = 2'd0;
            end else if (lat_reg == LAT_LAST) begin
               state_next = DONE;
            end else begin
               lat_next = lat_reg + 2'd1;
            end
         end
         DONE: begin
            din_next   = fill_sel_reg ? fill_reg : ram_q;
            wait_next  = 1'b0;
            req_next   = 1'b0;
            state_next = IDLE;
`ifdef NVRAM_CHECKSUM_EN
            // Only bytes read from RAM contribute to the running sum.
            if (!fill_sel_reg)
               sum_next = sum_reg + ram_q;
`endif
         end
         default: state_next = IDLE;
      endcase

      // Losing the session abandons whatever is in flight; the last byte stays visible.
      if (!active) begin
         state_next = IDLE;
         wait_next  = 1'b0;
         req_next   = 1'b0;
         din_next   = din_reg;
         lat_next   = 2'd0;
`ifdef NVRAM_CHECKSUM_EN
         sum_next   = sum_reg;
`endif
      end

`ifdef NVRAM_CHECKSUM_EN
      if (active && !active_reg)
         sum_next = 8'd0;
`endif
   end

   assign ioctl_din  = din_reg;
   assign ioctl_wait = wait_reg;
   assign ram_req    = req_reg;
   assign ram_addr   = addr_reg;
   assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_nvram_uploader.sv
// Randomized self-checking bench for nvram_uploader against a transaction-level model.
// Also covers the NVRAM_CHECKSUM_EN build when that macro is defined.
module tb_nvram_uploader;

   localparam int SIZE   = 1024;
   localparam int RD_LAT = 1;

   logic        clk_sys      = 1'b0;
   logic        reset        = 1'b1;
   logic        ioctl_upload = 1'b0;
   logic [7:0]  ioctl_index  = 8'd4;
   logic        ioctl_rd     = 1'b0;
   logic [24:0] ioctl_addr   = '0;
   logic        ram_gnt      = 1'b0;
   logic [7:0]  ram_q        = 8'd0;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic        ram_req;
   logic [9:0]  ram_addr;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk_sys = ~clk_sys;

   nvram_uploader #(
      .UPLOAD_INDEX(8'd4), .ADDR_W(10), .SIZE(SIZE), .RD_LAT(RD_LAT)
   ) dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload),
      .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
      .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .ram_req(ram_req),
      .ram_gnt(ram_gnt), .ram_addr(ram_addr), .ram_q(ram_q), .busy(busy)
   );

   // RAM behind the arbiter: returns real data only on granted cycles.
   logic [7:0] mem [0:SIZE-1];
   always @(posedge clk_sys) ram_q <= ram_gnt ? mem[ram_addr] : 8'($urandom);

   // Transaction-level model: a request completes one edge after
   // RD_LAT+1 consecutive granted edges; a ungranted edge restarts the run.
   bit          m_pend, m_oob, m_req, m_wait, m_prev_active;
   logic [7:0]  m_din, m_fill, m_sum;
   logic [24:0] m_addr;
   int          m_streak;
   bit          chk_en   = 1'b0;
   bit          saw_req  = 1'b0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_oob = 0; m_req = 0; m_wait = 0; m_prev_active = 0;
      m_din = 8'd0; m_fill = 8'd0; m_sum = 8'd0; m_addr = '0; m_streak = 0;
   endtask

   always @(negedge clk_sys) begin
      if (chk_en) begin
         chk("ioctl_wait", 32'(ioctl_wait), 32'(m_wait));
         chk("ram_req", 32'(ram_req), 32'(m_req));
         chk("busy", 32'(busy), 32'(m_pend));
         chk("ioctl_din", 32'(ioctl_din), 32'(m_din));
         if (m_req)
            chk("ram_addr", 32'(ram_addr), 32'(m_addr[9:0]));
      end
      if (ram_req) saw_req = 1'b1;
   end

   // One clock: drive inputs, take the edge, then advance the model.
   task automatic cyc(bit rd, logic [24:0] a, bit g);
      bit act;
      ioctl_rd = rd; ioctl_addr = a; ram_gnt = g;
      @(posedge clk_sys);
      #1;
      act = ioctl_upload && (ioctl_index == 8'd4);
      if (reset) begin
         model_reset();
      end else if (!act) begin
         m_pend = 0; m_wait = 0; m_req = 0; m_streak = 0;
         m_prev_active = 0;
      end else begin
         if (m_pend) begin
            if (m_oob) begin
               m_din = m_fill; m_wait = 0; m_pend = 0;
            end else if (m_streak == RD_LAT + 1) begin
               m_din = mem[m_addr[9:0]];
               m_sum = m_sum + m_din;
               m_wait = 0; m_req = 0; m_pend = 0;
            end else begin
               m_streak = g ? m_streak + 1 : 0;
            end
         end else if (rd) begin
            m_pend = 1; m_wait = 1;
            if (a < 25'(SIZE)) begin
               m_oob = 0; m_req = 1; m_streak = 0; m_addr = a;
            end else begin
               m_oob  = 1;
               m_fill = 8'hFF;
`ifdef NVRAM_CHECKSUM_EN
               if (a == 25'(SIZE)) m_fill = 8'd0 - m_sum;
`endif
            end
         end
         if (!m_prev_active) m_sum = 8'd0;
         m_prev_active = 1;
      end
   endtask

   task automatic finish_read(bit g, inout int lat);
      while (ioctl_wait && lat < 60) begin
         cyc(0, '0, g);
         lat++;
      end
      chk("wait_timeout", 32'(ioctl_wait), 32'd0);
   endtask

   task automatic read_byte(logic [24:0] a, output int lat);
      cyc(1, a, 1);
      lat = 0;
      finish_read(1, lat);
   endtask

   int lat;

   initial begin
      foreach (mem[i]) mem[i] = 8'($urandom);
      model_reset();
      cyc(0, '0, 0);
      chk("reset_din", 32'(ioctl_din), 32'h0);
      chk("reset_wait", 32'(ioctl_wait), 32'h0);
      chk("reset_req", 32'(ram_req), 32'h0);
      chk("reset_addr", 32'(ram_addr), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk_en = 1'b1;
      cyc(0, '0, 0);
      reset = 1'b0;
      cyc(0, '0, 0);

      // Wrong index: every rd is ignored and outputs remain at reset values.
      ioctl_upload = 1'b1; ioctl_index = 8'd0; saw_req = 1'b0;
      for (int i = 0; i < 6; i++) cyc(i[0], 25'(i * 3), 1);
      chk("idx0_din", 32'(ioctl_din), 32'h0);
      chk("idx0_busy", 32'(busy), 32'h0);
      chk("idx0_no_req", 32'(saw_req), 32'h0);
      ioctl_index = 8'd4;
      cyc(0, '0, 1);

      // RAM[5]=3C with grant tied high: wait falls 3 edges after rd.
      mem[5] = 8'h3C;
      read_byte(25'd5, lat);
      chk("rd5_latency", 32'(lat), 32'd3);
      chk("rd5_data", 32'(ioctl_din), 32'h3C);

      // Grant withheld for 10 edges: latency 10 + RD_LAT + 2.
      mem[77] = 8'hA5;
      cyc(1, 25'd77, 0);
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(0, '0, 0);
         lat++;
         chk("gnt_wait_req_held", 32'(ram_req), 32'd1);
      end
      finish_read(1, lat);
      chk("gnt_wait_latency", 32'(lat), 32'd13);
      chk("gnt_wait_data", 32'(ioctl_din), 32'hA5);

      // Out of range: fill byte, single wait cycle, no RAM request.
      saw_req = 1'b0;
      read_byte(25'd1500, lat);
      chk("oob_latency", 32'(lat), 32'd1);
      chk("oob_data", 32'(ioctl_din), 32'hFF);
      chk("oob_no_req", 32'(saw_req), 32'd0);

      // Session dropped during LAT, then a fresh session.
      cyc(1, 25'd7, 1);
      cyc(0, '0, 1);
      ioctl_upload = 1'b0;
      cyc(0, '0, 1);
      chk("drop_busy", 32'(busy), 32'd0);
      chk("drop_wait", 32'(ioctl_wait), 32'd0);
      chk("drop_req", 32'(ram_req), 32'd0);
      chk("drop_din_held", 32'(ioctl_din), 32'hFF);
      ioctl_upload = 1'b1;
      mem[9] = 8'h5A;
      read_byte(25'd9, lat);
      chk("resume_latency", 32'(lat), 32'd3);
      chk("resume_data", 32'(ioctl_din), 32'h5A);

      // Reset in the middle of a transfer.
      cyc(1, 25'd3, 1);
      cyc(0, '0, 1);
      reset = 1'b1;
      model_reset();
      cyc(0, '0, 1);
      chk("midreset_din", 32'(ioctl_din), 32'h0);
      chk("midreset_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      cyc(0, '0, 1);

`ifdef NVRAM_CHECKSUM_EN
      ioctl_upload = 1'b0;
      cyc(0, '0, 1);
      ioctl_upload = 1'b1;
      cyc(0, '0, 1);
      for (int i = 0; i < 4; i++) begin
         mem[i] = 8'(i + 1);
         read_byte(25'(i), lat);
      end
      read_byte(25'(SIZE), lat);
      chk("csum_latency", 32'(lat), 32'd1);
      chk("csum_byte", 32'(ioctl_din), 32'hF6);
`endif

      // Randomized traffic: rd pulses at any time, random grants and session drops.
      for (int n = 0; n < 3000; n++) begin
         int       sel;
         logic [24:0] a;
         ioctl_upload = ($urandom_range(0, 99) != 0);
         ioctl_index  = ($urandom_range(0, 49) == 0) ? 8'd0 : 8'd4;
         sel = $urandom_range(0, 9);
         if (sel < 7)       a = 25'($urandom_range(0, SIZE - 1));
         else if (sel == 7) a = 25'(SIZE);
         else if (sel == 8) a = 25'($urandom_range(SIZE + 1, 33554431));
         else               a = 25'(SIZE - 1);
         cyc($urandom_range(0, 2) == 0, a, $urandom_range(0, 3) != 0);
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
